// File: rtl/gsim_param.sv
// Parametrised Gauss-Seidel solver for the 7-point banded system 20,-13,6,-1.
// One engine: load b, sweep in place one unknown per cycle, then drain x with ready/valid.
module gsim_param #(
  parameter int unsigned N        = 16,
  parameter int unsigned B_W      = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned MAX_ITER = 100,
  parameter int unsigned TOL      = 0,
  parameter int unsigned ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic signed [B_W-1:0]   b_in,
  output logic                    in_ready,
  input  logic                    early_stop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] x_out,
  output logic [ITER_W-1:0]       iter_out
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW    = OUT_W + 6;
  localparam int unsigned PW    = AW + 13;
  localparam int unsigned MD_W  = OUT_W + 1;
  localparam int          NI    = int'(N);
  localparam logic [IDX_W-1:0]  LAST     = IDX_W'(N - 1);
  localparam logic [ITER_W-1:0] ITER_LST = ITER_W'(MAX_ITER - 1);
  localparam logic signed [AW-1:0] C13 = AW'(13);
  localparam logic signed [AW-1:0] C6  = AW'(6);

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_SEND} state_t;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [ITER_W-1:0]        r_iter;
  logic [MD_W-1:0]          r_maxd;
  logic signed [B_W-1:0]    r_b [N];
  logic signed [OUT_W-1:0]  r_x [N];

  logic signed [OUT_W-1:0]  w_xm [1:3];
  logic signed [OUT_W-1:0]  w_xp [1:3];
  logic signed [AW-1:0]     w_bsh, w_s1, w_s2, w_s3, w_acc;
  logic signed [PW-1:0]     w_prod, w_shr;
  logic [PW-OUT_W:0]        w_hi;
  logic signed [OUT_W-1:0]  w_x_old, w_x_new, w_x0_fwd;
  logic signed [MD_W-1:0]   w_diff;
  logic [MD_W-1:0]          w_d, w_maxd_all;
  logic                     w_stop;
  logic [IDX_W-1:0]         w_idx_inc;

  // Neighbour fetch: lower indices already hold this sweep's values, upper ones the previous sweep's.
  always_comb begin
    for (int k = 1; k <= 3; k++) begin
      w_xm[k] = '0;
      w_xp[k] = '0;
      if (int'(r_idx) >= k)
        w_xm[k] = r_x[r_idx - IDX_W'(k)];
      if (int'(r_idx) + k <= NI - 1)
        w_xp[k] = r_x[r_idx + IDX_W'(k)];
    end
  end

  // Exact accumulate, multiply by 3277/65536 (~1/20) with floor, then saturate.
  always_comb begin
    w_x_old = r_x[r_idx];
    w_bsh   = AW'(r_b[r_idx]) <<< FRAC_W;
    w_s1    = AW'(w_xm[1]) + AW'(w_xp[1]);
    w_s2    = AW'(w_xm[2]) + AW'(w_xp[2]);
    w_s3    = AW'(w_xm[3]) + AW'(w_xp[3]);
    w_acc   = w_bsh + C13 * w_s1 - C6 * w_s2 + w_s3;
    w_prod  = PW'(w_acc) * PW'(3277);
    w_shr   = w_prod >>> 16;
    w_hi    = w_shr[PW-1:OUT_W-1];
    if ((&w_hi) || (~|w_hi))
      w_x_new = w_shr[OUT_W-1:0];
    else if (w_shr[PW-1])
      w_x_new = {1'b1, {(OUT_W-1){1'b0}}};
    else
      w_x_new = {1'b0, {(OUT_W-1){1'b1}}};
    w_diff     = MD_W'(w_x_new) - MD_W'(w_x_old);
    w_d        = w_diff[MD_W-1] ? MD_W'(-w_diff) : MD_W'(w_diff);
    w_maxd_all = (w_d > r_maxd) ? w_d : r_maxd;
    w_stop     = (early_stop && (w_maxd_all <= MD_W'(TOL))) || (r_iter == ITER_LST);
    w_x0_fwd   = (N == 1) ? w_x_new : r_x[0];
    w_idx_inc  = r_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_out     <= '0;
      iter_out  <= '0;
      r_idx     <= '0;
      r_iter    <= '0;
      r_maxd    <= '0;
      for (int i = 0; i < NI; i++) begin
        r_b[i] <= '0;
        r_x[i] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_en) begin
            r_b[r_idx] <= b_in;
            r_x[r_idx] <= OUT_W'(b_in) <<< FRAC_W;
            if (r_idx == LAST) begin
              r_idx    <= '0;
              r_iter   <= '0;
              r_maxd   <= '0;
              in_ready <= 1'b0;
              r_state  <= S_CALC;
            end else begin
              r_idx <= w_idx_inc;
            end
          end
        end
        S_CALC: begin
          r_x[r_idx] <= w_x_new;
          if (r_idx == LAST) begin
            iter_out <= r_iter + ITER_W'(1);
            r_idx    <= '0;
            if (w_stop) begin
              out_valid <= 1'b1;
              x_out     <= w_x0_fwd;
              r_state   <= S_SEND;
            end else begin
              r_iter <= r_iter + ITER_W'(1);
              r_maxd <= '0;
            end
          end else begin
            r_idx  <= w_idx_inc;
            r_maxd <= w_maxd_all;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (r_idx == LAST) begin
              r_idx     <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              r_state   <= S_LOAD;
            end else begin
              r_idx <= w_idx_inc;
              x_out <= r_x[w_idx_inc];
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// Directed bench for gsim_param: a 16-unknown instance checked against a reference
// Gauss-Seidel model and a 1-unknown instance checked against hand-computed values.
module tb_gsim_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               a_in_en, a_in_ready, a_es, a_out_valid, a_out_ready;
  logic signed [15:0] a_b;
  logic signed [31:0] a_x;
  logic [6:0]         a_iter;

  logic               s_in_en, s_in_ready, s_es, s_out_valid, s_out_ready;
  logic signed [15:0] s_b;
  logic signed [31:0] s_x;
  logic [6:0]         s_iter;

  gsim_param #(.N(16)) u_a (
    .clk(clk), .reset(reset), .in_en(a_in_en), .b_in(a_b), .in_ready(a_in_ready),
    .early_stop(a_es), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .x_out(a_x), .iter_out(a_iter));

  gsim_param #(.N(1)) u_s (
    .clk(clk), .reset(reset), .in_en(s_in_en), .b_in(s_b), .in_ready(s_in_ready),
    .early_stop(s_es), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .x_out(s_x), .iter_out(s_iter));

  typedef longint vec_t [16];
  localparam longint XMAX = 64'sd2147483647;
  localparam longint XMIN = -XMAX - 64'sd1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic longint nb(input vec_t x, input int j);
    return (j < 0 || j > 15) ? 64'sd0 : x[j];
  endfunction

  // Reference solver straight from the update equation, in 64-bit arithmetic.
  function automatic void model16(input vec_t b, input bit es, output vec_t x, output int it);
    longint acc, p, s, d, maxd;
    for (int i = 0; i < 16; i++) x[i] = b[i] * 65536;
    it = 0;
    for (int sw = 0; sw < 100; sw++) begin
      maxd = 0;
      for (int i = 0; i < 16; i++) begin
        acc = b[i] * 65536 + 13 * (nb(x, i-1) + nb(x, i+1))
              - 6 * (nb(x, i-2) + nb(x, i+2)) + (nb(x, i-3) + nb(x, i+3));
        p = acc * 3277;
        s = p >>> 16;
        if (s > XMAX) s = XMAX;
        else if (s < XMIN) s = XMIN;
        d = s - x[i];
        if (d < 0) d = -d;
        if (d > maxd) maxd = d;
        x[i] = s;
      end
      it = sw + 1;
      if (es && maxd == 0) break;
    end
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = longint'($urandom_range(65534)) - 32767;
    return v;
  endfunction

  task automatic load16(input vec_t bv, input bit gaps);
    int g;
    for (int i = 0; i < 16; i++) begin
      g = gaps ? int'($urandom_range(2)) : 0;
      repeat (g) begin
        a_in_en = 1'b0; a_b = 16'sh5A5A;
        @(negedge clk);
      end
      a_in_en = 1'b1; a_b = 16'(bv[i]);
      @(negedge clk);
    end
    a_in_en = 1'b0;
  endtask

  task automatic wait_valid(input bit which, input bit noise, input int budget,
                            output bit ok, output int cyc);
    cyc = 0;
    while (!(which ? s_out_valid : a_out_valid) && cyc < budget) begin
      a_in_en = noise ? 1'($urandom_range(1)) : 1'b0;
      a_b = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    a_in_en = 1'b0;
    ok = which ? s_out_valid : a_out_valid;
  endtask

  task automatic drain16(input bit bp, input bit noise, input int budget,
                         output vec_t got, output int cnt, output int cyc);
    for (int i = 0; i < 16; i++) got[i] = 64'sh7EAD;
    cnt = 0; cyc = 0;
    while (cnt < 16 && cyc < budget) begin
      a_out_ready = bp ? 1'($urandom_range(1)) : 1'b1;
      a_in_en = noise ? 1'($urandom_range(1)) : 1'b0;
      a_b = 16'($urandom);
      if (a_out_valid && a_out_ready) begin
        got[cnt] = longint'(a_x);
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    a_out_ready = 1'b0;
    a_in_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_chk++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_chk++; if (a_x !== 32'sd0) $display("FAIL reset_x_out got=%0d exp=0", a_x); else n_pass++;
    n_chk++; if (a_iter !== 7'd0) $display("FAIL reset_iter_out got=%0d exp=0", a_iter); else n_pass++;
    n_chk++; if (s_in_ready !== 1'b1) $display("FAIL reset_n1_in_ready got=%b exp=1", s_in_ready); else n_pass++;
  endtask

  task automatic test_zero();
    vec_t b, got;
    bit ok; int cyc, cnt, dc;
    for (int i = 0; i < 16; i++) b[i] = 0;
    a_es = 1'b1;
    load16(b, 1'b0);
    n_chk++; if (a_in_ready !== 1'b0) $display("FAIL zero_in_ready_calc got=%b exp=0", a_in_ready); else n_pass++;
    wait_valid(1'b0, 1'b0, 200, ok, cyc);
    n_chk++; if (!ok) $display("FAIL zero_valid_timeout got=0 exp=1"); else n_pass++;
    n_chk++; if (cyc !== 16) $display("FAIL zero_calc_cycles got=%0d exp=16", cyc); else n_pass++;
    n_chk++; if (a_iter !== 7'd1) $display("FAIL zero_iter got=%0d exp=1", a_iter); else n_pass++;
    drain16(1'b0, 1'b0, 100, got, cnt, dc);
    n_chk++; if (dc !== 16 || cnt !== 16) $display("FAIL zero_drain_len got=%0d/%0d exp=16/16", cnt, dc); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== 64'sd0) $display("FAIL zero_x%0d got=%0d exp=0", i, got[i]); else n_pass++;
    end
    n_chk++; if (a_in_ready !== 1'b1) $display("FAIL zero_in_ready_after got=%b exp=1", a_in_ready); else n_pass++;
  endtask

  task automatic n1_run(input bit es, input int exp_cyc, input int exp_it, input string tag);
    bit ok; int cyc;
    s_es = es;
    s_in_en = 1'b1; s_b = 16'sd20;
    @(negedge clk);
    s_in_en = 1'b0;
    wait_valid(1'b1, 1'b0, 300, ok, cyc);
    n_chk++; if (!ok) $display("FAIL %s_valid_timeout got=0 exp=1", tag); else n_pass++;
    n_chk++; if (cyc !== exp_cyc) $display("FAIL %s_latency got=%0d exp=%0d", tag, cyc, exp_cyc); else n_pass++;
    n_chk++; if (s_iter !== 7'(exp_it)) $display("FAIL %s_iter got=%0d exp=%0d", tag, s_iter, exp_it); else n_pass++;
    n_chk++; if (s_x !== 32'sh00010004) $display("FAIL %s_x got=%h exp=00010004", tag, s_x); else n_pass++;
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    n_chk++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0)
      $display("FAIL %s_return_load got=%b%b exp=10", tag, s_in_ready, s_out_valid); else n_pass++;
  endtask

  task automatic test_single_conv();
    n1_run(1'b1, 2, 2, "n1_conv");
  endtask

  task automatic test_iter_cap();
    n1_run(1'b0, 100, 100, "n1_cap");
  endtask

  task automatic golden_run(input vec_t b, input bit gaps, input bit bp, input string tag);
    vec_t ex, got;
    int eit, cyc, cnt, dc; bit ok;
    model16(b, 1'b1, ex, eit);
    a_es = 1'b1;
    load16(b, gaps);
    wait_valid(1'b0, gaps, 1700, ok, cyc);
    n_chk++; if (!ok) $display("FAIL %s_valid_timeout got=0 exp=1", tag); else n_pass++;
    n_chk++; if (cyc !== eit * 16) $display("FAIL %s_calc_cycles got=%0d exp=%0d", tag, cyc, eit * 16); else n_pass++;
    n_chk++; if (int'(a_iter) !== eit) $display("FAIL %s_iter got=%0d exp=%0d", tag, a_iter, eit); else n_pass++;
    drain16(bp, gaps, 400, got, cnt, dc);
    n_chk++; if (cnt !== 16) $display("FAIL %s_drain_count got=%0d exp=16", tag, cnt); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (got[i] !== ex[i]) $display("FAIL %s_x%0d got=%0d exp=%0d", tag, i, got[i], ex[i]); else n_pass++;
    end
    n_chk++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
      $display("FAIL %s_return_load got=%b%b exp=10", tag, a_in_ready, a_out_valid); else n_pass++;
  endtask

  task automatic test_golden();
    golden_run(rand_vec(), 1'b0, 1'b0, "golden");
  endtask

  task automatic test_reset_mid_calc();
    vec_t b;
    b = rand_vec();
    a_es = 1'b1;
    load16(b, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (a_out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_chk++; if (a_in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got=%b exp=1", a_in_ready); else n_pass++;
    n_chk++; if (a_iter !== 7'd0 || a_x !== 32'sd0)
      $display("FAIL rst_mid_outputs got=%0d/%0d exp=0/0", a_iter, a_x); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    golden_run(b, 1'b0, 1'b0, "rst_rerun");
  endtask

  task automatic test_gaps_backpressure();
    golden_run(rand_vec(), 1'b1, 1'b1, "gaps_bp");
  endtask

  initial begin
    reset = 1'b1;
    a_in_en = 1'b0; a_b = '0; a_es = 1'b0; a_out_ready = 1'b0;
    s_in_en = 1'b0; s_b = '0; s_es = 1'b0; s_out_ready = 1'b0;
    test_reset();
    test_zero();
    test_single_conv();
    test_iter_cap();
    test_golden();
    test_reset_mid_calc();
    test_gaps_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
